// File: rtl/vpe_rf_writeback.sv
// -----------------------------------------------------------------------------
// vpe_rf_writeback
//
// Writeback stage between the vector bias adder and the register file.
// Incoming beats are optionally passed through a per-lane ReLU. Each beat's
// write mode is decoded into a byte mask, and the beat is then queued in a
// small FIFO. The head of the FIFO is presented to the register file as a
// valid/ready write request.
//
// The source cannot be stalled. A beat that arrives while the queue is full
// and nothing drains on that edge is dropped, and a sticky overflow flag is
// raised. Completed writes are counted in a free-running wrapping counter.
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   i_data       eight signed int8 lanes, lane k = bits [8k+7:8k]
//   i_data_v     beat valid (no backpressure)
//   i_en_relu    clamp negative lanes of this beat to zero
//   i_rf_idx     destination register-file entry
//   i_rf_mux     00 full word, 01 lanes 0-3, 10 lanes 4-7, 11 discard
//   i_wr_ready   register file accepts the presented write
//   i_ovf_clr    clear the sticky overflow flag
//   o_wr_en      write request valid (queue not empty)
//   o_wr_addr    head entry address
//   o_wr_data    head entry data
//   o_wr_mask    head entry byte enables
//   o_fifo_cnt   queue occupancy
//   o_overflow   sticky: a valid beat was dropped
//   o_wr_cnt     completed writes, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module vpe_rf_writeback #(
  parameter int FIFO_DEPTH = 4,   // power of two, >= 2
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [63:0]                   i_data,
  input  logic                          i_data_v,
  input  logic                          i_en_relu,
  input  logic [4:0]                    i_rf_idx,
  input  logic [1:0]                    i_rf_mux,
  input  logic                          i_wr_ready,
  input  logic                          i_ovf_clr,
  output logic                          o_wr_en,
  output logic [4:0]                    o_wr_addr,
  output logic [63:0]                   o_wr_data,
  output logic [7:0]                    o_wr_mask,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt,
  output logic                          o_overflow,
  output logic [CNT_W-1:0]              o_wr_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {
    MUX_FULL    = 2'b00,
    MUX_LO      = 2'b01,
    MUX_HI      = 2'b10,
    MUX_DISCARD = 2'b11
  } rf_mux_e;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  idx;
    logic [7:0]  mask;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Input-side transforms
  // ---------------------------------------------------------------------------

  // Lanes with the sign bit set are clamped to zero. Lanes that are already
  // non-negative pass through untouched.
  function automatic logic [63:0] relu_lanes(input logic [63:0] data);
    logic [63:0] res;
    res = data;
    for (int k = 0; k < 8; k++) begin
      if (data[8*k+7]) res[8*k +: 8] = 8'h00;
    end
    return res;
  endfunction

  function automatic logic [7:0] decode_mask(input rf_mux_e mux);
    logic [7:0] mask;
    case (mux)
      MUX_FULL: mask = 8'hFF;
      MUX_LO:   mask = 8'h0F;
      MUX_HI:   mask = 8'hF0;
      default:  mask = 8'h00;   // discard beats never reach the queue
    endcase
    return mask;
  endfunction

  rf_mux_e in_mux;
  entry_t  in_entry;
  logic    in_beat;       // valid beat that wants a queue slot

  always_comb begin
    in_mux         = rf_mux_e'(i_rf_mux);
    in_beat        = i_data_v && (in_mux != MUX_DISCARD);
    in_entry.data  = i_en_relu ? relu_lanes(i_data) : i_data;
    in_entry.idx   = i_rf_idx;
    in_entry.mask  = decode_mask(in_mux);
  end

  // ---------------------------------------------------------------------------
  // Queue state
  // ---------------------------------------------------------------------------
  entry_t             mem_q [FIFO_DEPTH];
  entry_t             mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [OCC_W-1:0]   cnt_q,  cnt_d;
  logic               ovf_q,  ovf_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;

  logic full;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    mem_d    = mem_q;
    head_d   = head_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    wr_cnt_d = wr_cnt_q;

    full = (cnt_q == OCC_W'(FIFO_DEPTH));
    pop  = (cnt_q != '0) && i_wr_ready;
    // A full queue still accepts a beat when the head drains on the same edge.
    push = in_beat && (!full || pop);
    drop = in_beat && full && !pop;

    if (push) begin
      mem_d[tail_q] = in_entry;
      tail_d        = tail_q + PTR_W'(1);   // power-of-two depth wraps naturally
    end

    if (pop) begin
      head_d   = head_q + PTR_W'(1);
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + OCC_W'(1);
      2'b01:   cnt_d = cnt_q - OCC_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // A drop on the same edge as a clear wins, so that event is not lost.
    if (drop)           ovf_d = 1'b1;
    else if (i_ovf_clr) ovf_d = 1'b0;
  end

  // NOTE: non-blocking assignments for all state, so every flop samples the
  // values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      wr_cnt_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // NOTE: the entry storage has no reset. An entry is only observed after it
  // has been written, and the outputs are forced to zero while the queue is
  // empty, so stale contents never escape.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs: driven only from registered state, so there is no input-to-output
  // combinational path.
  // ---------------------------------------------------------------------------
  entry_t head_entry;

  always_comb begin
    o_wr_en    = (cnt_q != '0);
    head_entry = o_wr_en ? mem_q[head_q] : '0;
    o_wr_addr  = head_entry.idx;
    o_wr_data  = head_entry.data;
    o_wr_mask  = head_entry.mask;
    o_fifo_cnt = cnt_q;
    o_overflow = ovf_q;
    o_wr_cnt   = wr_cnt_q;
  end

endmodule

// File: tb/tb_vpe_rf_writeback.sv
// -----------------------------------------------------------------------------
// tb_vpe_rf_writeback
//
// Directed bench for vpe_rf_writeback. Single-beat transactions come from a
// vector table. Hand-written sequences cover queue fill and overflow,
// simultaneous push/pop at full, clear priority, mid-operation reset, the
// first edge after reset, and wrap-around of the write counter.
// -----------------------------------------------------------------------------
module tb_vpe_rf_writeback;

  logic        clk;
  logic        rst_n;
  logic [63:0] i_data;
  logic        i_data_v;
  logic        i_en_relu;
  logic [4:0]  i_rf_idx;
  logic [1:0]  i_rf_mux;
  logic        i_wr_ready;
  logic        i_ovf_clr;
  logic        o_wr_en;
  logic [4:0]  o_wr_addr;
  logic [63:0] o_wr_data;
  logic [7:0]  o_wr_mask;
  logic [2:0]  o_fifo_cnt;
  logic        o_overflow;
  logic [15:0] o_wr_cnt;

  vpe_rf_writeback #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_data     (i_data),
    .i_data_v   (i_data_v),
    .i_en_relu  (i_en_relu),
    .i_rf_idx   (i_rf_idx),
    .i_rf_mux   (i_rf_mux),
    .i_wr_ready (i_wr_ready),
    .i_ovf_clr  (i_ovf_clr),
    .o_wr_en    (o_wr_en),
    .o_wr_addr  (o_wr_addr),
    .o_wr_data  (o_wr_data),
    .o_wr_mask  (o_wr_mask),
    .o_fifo_cnt (o_fifo_cnt),
    .o_overflow (o_overflow),
    .o_wr_cnt   (o_wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  logic [15:0] exp_wr_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one rising edge, then step clear of it before driving or sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [4:0] idx, input logic [63:0] data);
    i_data    = data;
    i_rf_idx  = idx;
    i_rf_mux  = 2'b00;
    i_en_relu = 1'b0;
    i_data_v  = 1'b1;
    tick();
    i_data_v  = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " wr_en"},    64'(o_wr_en),    64'd0);
    check({tag, " fifo_cnt"}, 64'(o_fifo_cnt), 64'd0);
    check({tag, " overflow"}, 64'(o_overflow), 64'd0);
    check({tag, " wr_cnt"},   64'(o_wr_cnt),   64'd0);
    check({tag, " wr_addr"},  64'(o_wr_addr),  64'd0);
    check({tag, " wr_data"},  o_wr_data,       64'd0);
    check({tag, " wr_mask"},  64'(o_wr_mask),  64'd0);
  endtask

  typedef struct {
    logic [63:0] data;
    logic        relu;
    logic [4:0]  idx;
    logic [1:0]  mux;
    logic        exp_en;
    logic [63:0] exp_data;
    logic [7:0]  exp_mask;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{64'h80FF_7F01_0081_7F00, 1'b1, 5'd5,  2'b00, 1'b1, 64'h0000_7F01_0000_7F00, 8'hFF};
    vecs[1] = '{64'h80FF_7F01_0081_7F00, 1'b0, 5'd6,  2'b01, 1'b1, 64'h80FF_7F01_0081_7F00, 8'h0F};
    vecs[2] = '{64'h80FF_7F01_0081_7F00, 1'b0, 5'd7,  2'b10, 1'b1, 64'h80FF_7F01_0081_7F00, 8'hF0};
    vecs[3] = '{64'h80FF_7F01_0081_7F00, 1'b0, 5'd8,  2'b11, 1'b0, 64'h0,                  8'h00};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd31, 2'b01, 1'b1, 64'h0,                  8'h0F};
    vecs[5] = '{64'h7F7F_0102_7E00_1133, 1'b1, 5'd0,  2'b10, 1'b1, 64'h7F7F_0102_7E00_1133, 8'hF0};

    rst_n      = 1'b0;
    i_data     = '0;
    i_data_v   = 1'b0;
    i_en_relu  = 1'b0;
    i_rf_idx   = '0;
    i_rf_mux   = '0;
    i_wr_ready = 1'b0;
    i_ovf_clr  = 1'b0;
    exp_wr_cnt = '0;

    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ---- single-beat vectors, register file always ready ----
    for (int i = 0; i < 6; i++) begin
      i_data     = vecs[i].data;
      i_en_relu  = vecs[i].relu;
      i_rf_idx   = vecs[i].idx;
      i_rf_mux   = vecs[i].mux;
      i_wr_ready = 1'b1;
      i_data_v   = 1'b1;
      tick();
      i_data_v   = 1'b0;
      check($sformatf("vec%0d wr_en", i), 64'(o_wr_en), 64'(vecs[i].exp_en));
      if (vecs[i].exp_en) begin
        check($sformatf("vec%0d addr", i), 64'(o_wr_addr), 64'(vecs[i].idx));
        check($sformatf("vec%0d data", i), o_wr_data, vecs[i].exp_data);
        check($sformatf("vec%0d mask", i), 64'(o_wr_mask), 64'(vecs[i].exp_mask));
        exp_wr_cnt++;
      end
      tick();
      check($sformatf("vec%0d wr_cnt", i), 64'(o_wr_cnt), 64'(exp_wr_cnt));
      check($sformatf("vec%0d drained", i), 64'(o_wr_en), 64'd0);
    end
    check("vec overflow", 64'(o_overflow), 64'd0);

    // ---- fill with 5 beats while stalled: beat 5 dropped ----
    i_wr_ready = 1'b0;
    for (int k = 1; k <= 5; k++) push_beat(5'(k), {8{8'(k)}});
    check("fill cnt", 64'(o_fifo_cnt), 64'd4);
    check("fill overflow", 64'(o_overflow), 64'd1);
    tick();
    check("stall addr held", 64'(o_wr_addr), 64'd1);
    check("stall data held", o_wr_data, {8{8'h01}});
    check("stall en held", 64'(o_wr_en), 64'd1);
    i_wr_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("drain%0d en", k), 64'(o_wr_en), 64'd1);
      check($sformatf("drain%0d addr", k), 64'(o_wr_addr), 64'(k));
      check($sformatf("drain%0d data", k), o_wr_data, {8{8'(k)}});
      tick();
      exp_wr_cnt++;
    end
    i_wr_ready = 1'b0;
    check("drain empty", 64'(o_wr_en), 64'd0);
    check("drain wr_cnt", 64'(o_wr_cnt), 64'(exp_wr_cnt));
    check("overflow sticky", 64'(o_overflow), 64'd1);
    i_ovf_clr = 1'b1;
    tick();
    i_ovf_clr = 1'b0;
    check("overflow cleared", 64'(o_overflow), 64'd0);

    // ---- full queue with simultaneous push and pop ----
    for (int k = 1; k <= 4; k++) push_beat(5'(k), {8{8'(k)}});
    check("full cnt", 64'(o_fifo_cnt), 64'd4);
    check("full no overflow", 64'(o_overflow), 64'd0);
    i_wr_ready = 1'b1;
    push_beat(5'd9, {8{8'h09}});
    exp_wr_cnt++;
    check("pushpop cnt", 64'(o_fifo_cnt), 64'd4);
    check("pushpop overflow", 64'(o_overflow), 64'd0);
    begin
      int order[4];
      order = '{2, 3, 4, 9};
      for (int j = 0; j < 4; j++) begin
        check($sformatf("pushpop order%0d", j), 64'(o_wr_addr), 64'(order[j]));
        tick();
        exp_wr_cnt++;
      end
    end
    check("pushpop empty", 64'(o_wr_en), 64'd0);
    check("pushpop wr_cnt", 64'(o_wr_cnt), 64'(exp_wr_cnt));

    // ---- drop and clear on the same edge: drop wins ----
    i_wr_ready = 1'b0;
    for (int k = 1; k <= 4; k++) push_beat(5'(k + 10), {8{8'(k)}});
    i_ovf_clr = 1'b1;
    push_beat(5'd20, {8{8'h20}});
    check("drop beats clr", 64'(o_overflow), 64'd1);
    check("drop cnt", 64'(o_fifo_cnt), 64'd4);
    tick();
    i_ovf_clr = 1'b0;
    check("clr alone", 64'(o_overflow), 64'd0);

    // ---- reset mid-operation with 3 entries queued ----
    i_wr_ready = 1'b1;
    tick();
    i_wr_ready = 1'b0;
    check("pre-reset cnt", 64'(o_fifo_cnt), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    exp_wr_cnt = '0;
    check_zero_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    i_wr_ready = 1'b1;
    tick();
    tick();
    check("post-reset idle en", 64'(o_wr_en), 64'd0);
    check("post-reset idle cnt", 64'(o_fifo_cnt), 64'd0);
    check("post-reset wr_cnt", 64'(o_wr_cnt), 64'd0);

    // ---- beat on the first edge after reset release ----
    #2;
    rst_n = 1'b0;
    i_wr_ready = 1'b0;
    i_data     = 64'h0123_4567_89AB_CDEF;
    i_rf_idx   = 5'd17;
    i_rf_mux   = 2'b00;
    i_en_relu  = 1'b0;
    i_data_v   = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    i_data_v = 1'b0;
    check("first-edge en", 64'(o_wr_en), 64'd1);
    check("first-edge addr", 64'(o_wr_addr), 64'd17);
    check("first-edge data", o_wr_data, 64'h0123_4567_89AB_CDEF);
    i_wr_ready = 1'b1;
    tick();
    check("first-edge wr_cnt", 64'(o_wr_cnt), 64'd1);

    // ---- write counter wrap: 65535 writes then one more ----
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    i_data   = 64'h1111_2222_3333_4444;
    i_rf_idx = 5'd3;
    i_rf_mux = 2'b00;
    i_data_v = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    i_data_v = 1'b0;
    tick();
    check("wrap preload", 64'(o_wr_cnt), 64'hFFFF);
    check("wrap no overflow", 64'(o_overflow), 64'd0);
    check("wrap empty", 64'(o_wr_en), 64'd0);
    push_beat(5'd4, 64'h5);
    tick();
    check("wrap to zero", 64'(o_wr_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/vpe_rf_writeback.md
VPE_RF_WRITEBACK -- requirements
Module: vpe_rf_writeback

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: writeback queue entries; power of two, >=2.
REQ-002 Parameter CNT_W, default 16: width of the completed-write counter.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_data  input  64  eight signed int8 lanes from the bias adder; lane k = bits [8k+7:8k].
REQ-006 i_data_v  input  1  i_data and sideband valid this cycle; no backpressure toward the source.
REQ-007 i_en_relu  input  1  apply ReLU to this beat.
REQ-008 i_rf_idx  input  5  destination register-file entry.
REQ-009 i_rf_mux  input  2  write mode: 00 full word, 01 low half (lanes 0-3), 10 high half (lanes 4-7), 11 discard.
REQ-010 i_wr_ready  input  1  register file accepts the presented write this cycle.
REQ-011 i_ovf_clr  input  1  clears o_overflow.
REQ-012 o_wr_en  output  1  write request valid.
REQ-013 o_wr_addr  output  5  register-file address.
REQ-014 o_wr_data  output  64  write data.
REQ-015 o_wr_mask  output  8  byte enables, bit k = lane k.
REQ-016 o_fifo_cnt  output  $clog2(FIFO_DEPTH)+1  current queue occupancy.
REQ-017 o_overflow  output  1  sticky: a valid beat was dropped.
REQ-018 o_wr_cnt  output  CNT_W  completed writes, wraps modulo 2^CNT_W.

Function
REQ-019 ReLU at input: when i_en_relu=1, each lane with bit7=1 becomes 8'h00; others pass unchanged; i_en_relu=0 passes all lanes unchanged.
REQ-020 Mask decode at input: 00 -> 8'hFF, 01 -> 8'h0F, 10 -> 8'hF0.
REQ-021 Beat with i_data_v=1 and i_rf_mux=11 is never enqueued, never sets o_overflow, never counts.
REQ-022 Push: on a rising edge with i_data_v=1, mux!=11, and (count<FIFO_DEPTH or pop this edge), the entry {data after ReLU, idx, mask} is written at the tail.
REQ-023 Pop: on a rising edge with o_wr_en=1 and i_wr_ready=1, the head entry is removed and o_wr_cnt increments by 1.
REQ-024 o_wr_en = (count!=0); o_wr_addr/o_wr_data/o_wr_mask = head entry fields; all held stable while o_wr_en=1 and i_wr_ready=0.
REQ-025 Latency: beat pushed into an empty queue at edge N -> o_wr_en=1 with its fields in the cycle following edge N; no combinational path from i_data* to o_wr_*.
REQ-026 Order: writes issued strictly in arrival order, including repeated same i_rf_idx.
REQ-027 Simultaneous push and pop: occupancy unchanged; accepted even when full.
REQ-028 Full and no pop: beat dropped, queue unchanged, o_overflow set at that edge.
REQ-029 i_ovf_clr=1 clears o_overflow; a drop at the same edge takes priority (flag stays 1).
REQ-030 Head/tail pointers wrap modulo FIFO_DEPTH; o_fifo_cnt never exceeds FIFO_DEPTH.
REQ-031 o_wr_cnt wraps from 2^CNT_W-1 to 0.

Reset
REQ-032 rst_n=0 immediately forces o_wr_en=0, o_fifo_cnt=0, o_overflow=0, o_wr_cnt=0, o_wr_addr=0, o_wr_data=0, o_wr_mask=0.
REQ-033 Reset mid-operation discards all queued entries; no write issued until a new beat is pushed after rst_n=1.
REQ-034 Beat presented on the first edge after rst_n deasserts is accepted normally.

Verification
REQ-035 i_data=64'h80FF_7F01_0081_7F00, relu=1, idx=5, mux=00, ready=1 -> next cycle o_wr_en=1, addr=5, data=64'h0000_7F01_0000_7F00, mask=8'hFF; o_wr_cnt=1 after the edge.
REQ-036 Same data, relu=0, mux=01 then mux=10 then mux=11 -> masks 8'h0F, 8'hF0, no third write; data unmodified.
REQ-037 ready=0, push 5 beats idx 1..5 back-to-back -> o_fifo_cnt=4, o_overflow=1, beat 5 lost; ready=1 -> writes addr 1,2,3,4 in order, one per cycle.
REQ-038 Full queue, i_data_v=1 and pop on same edge -> new beat accepted, count stays 4, o_overflow unchanged.
REQ-039 Queue holds 3 entries, rst_n pulsed low mid-cycle -> outputs zero at once, no writes after release until new input.
REQ-040 o_wr_cnt preloaded to 16'hFFFF by completing 65535 writes -> next completed write yields 0.
